// File: rtl/fsin_requester.sv
// -----------------------------------------------------------------------------
// fsin_requester
//   Initiator side of the iterative float-sine engine interface. Accepts one
//   angle request at a time and latches the operand and the clamped term count
//   onto the engine. It strobes the engine start for LOAD_CYCLES cycles, waits
//   for eng_done, captures the running sum and returns it on a valid/ready
//   response port.
//
//   Optional feature: define FSIN_REQ_TIMEOUT_EN to abort a RUN phase that
//   lasts TIMEOUT cycles without eng_done. The response then carries
//   resp_res = 32'h7FC00000 and resp_err = 1. When the macro is undefined,
//   RUN waits indefinitely and resp_err is tied to 0.
//
// Parameters
//   LOAD_CYCLES  cycles eng_fsin is held high per request (>= 1)
//   MAX_TERMS    clamp applied to req_n (engine limit is 31)
//   TIMEOUT      RUN-cycle limit before abort (timeout build only, 1..255)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/ready          request handshake
//   req_a, req_n             angle (IEEE single) and highest term index
//   resp_valid/ready         response handshake
//   resp_res, resp_err       result (IEEE single) and timeout flag
//   busy                     high in every state except IDLE
//   eng_fsin, eng_a, eng_b   engine start strobe, operand and term count
//   eng_done, eng_res        engine step-counter-zero pulse and running sum
// -----------------------------------------------------------------------------
module fsin_requester #(
    parameter int unsigned LOAD_CYCLES = 1,
    parameter int unsigned MAX_TERMS   = 31,
    parameter int unsigned TIMEOUT     = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [4:0]  req_n,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_res,
    output logic        resp_err,
    output logic        busy,
    output logic        eng_fsin,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_done,
    input  logic [31:0] eng_res
);

    localparam int unsigned LCW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int unsigned N_LIMIT    = (MAX_TERMS > 31) ? 31 : MAX_TERMS;
    localparam logic [4:0]  MAX_N      = 5'(N_LIMIT);
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    // Elaboration-time parameter sanity.
    if (LOAD_CYCLES < 1) begin : g_bad_load
        $error("fsin_requester: LOAD_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fsin_requester: TIMEOUT must be within 1..255");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_res_q, resp_res_d;
    logic           busy_q, busy_d;
    logic           eng_fsin_q, eng_fsin_d;
    logic [31:0]    eng_a_q, eng_a_d;
    logic [31:0]    eng_b_q, eng_b_d;
    logic [4:0]     n_clamped;

`ifdef FSIN_REQ_TIMEOUT_EN
    localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);
    logic [7:0]     run_cnt_q, run_cnt_d;
    logic           resp_err_q, resp_err_d;
`endif

    // Requested term count limited to what the engine supports.
    assign n_clamped = (req_n > MAX_N) ? MAX_N : req_n;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        resp_res_d   = resp_res_q;
        eng_a_d      = eng_a_q;
        eng_b_d      = eng_b_q;
`ifdef FSIN_REQ_TIMEOUT_EN
        run_cnt_d    = run_cnt_q;
        resp_err_d   = resp_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    eng_a_d    = req_a;
                    eng_b_d    = {27'b0, n_clamped};
                    load_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // eng_done is meaningless while the engine is being loaded.
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = ST_RUN;
`ifdef FSIN_REQ_TIMEOUT_EN
                    run_cnt_d = '0;
`endif
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end
            ST_RUN: begin
                if (eng_done) begin
                    state_d = ST_CAPT;
                end
`ifdef FSIN_REQ_TIMEOUT_EN
                else if (run_cnt_q == RUN_LAST) begin
                    resp_res_d = QNAN;
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    run_cnt_d = run_cnt_q + 8'd1;
                end
`endif
            end
            ST_CAPT: begin
                // One cycle after eng_done the sum includes the final term.
                resp_res_d = eng_res;
`ifdef FSIN_REQ_TIMEOUT_EN
                resp_err_d = 1'b0;
`endif
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and strobe outputs are decoded from the next state so
        // that they are registered yet aligned with the state they describe.
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        eng_fsin_d   = (state_d == ST_LOAD);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_res_q   <= '0;
            busy_q       <= 1'b0;
            eng_fsin_q   <= 1'b0;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_res_q   <= resp_res_d;
            busy_q       <= busy_d;
            eng_fsin_q   <= eng_fsin_d;
            eng_a_q      <= eng_a_d;
            eng_b_q      <= eng_b_d;
        end
    end

`ifdef FSIN_REQ_TIMEOUT_EN
    // RUN-phase watchdog and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            resp_err_q <= resp_err_d;
        end
    end
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_res   = resp_res_q;
    assign busy       = busy_q;
    assign eng_fsin   = eng_fsin_q;
    assign eng_a      = eng_a_q;
    assign eng_b      = eng_b_q;

endmodule
